dcache: RTL
===========

DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ADDR_SIZE, 32, address width.
- WORD_SIZE, 32, data word width.
- NUM_LINES, 64, number of cache lines; a power of two.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- cpu  cache_interface.slave  -  request port from the core.
- mem  cache_interface.master  -  port to backing memory.

Function
REQ-004 The cache SHALL be direct-mapped with one-word lines and write-through, no-write-allocate policy.
REQ-005 Address split:
- addr[1:0] = byte offset.
- index = addr[2 +: log2(NUM_LINES)].
- tag = remaining upper bits.
REQ-006 A transfer on either port SHALL occur only in a cycle where valid && ready; a master holds addr, wr_data, wr_size and write stable until then.
REQ-007 The FSM SHALL have these states: IDLE, FILL, WRITE_THRU, RESP.
REQ-008 Read hit in IDLE (cpu.valid, !cpu.write, valid bit set, tag match): cpu.ready=1 and cpu.miss=0 in the same cycle; cpu.rd_data = stored word; remain in IDLE.
REQ-009 Read miss in IDLE: go to FILL.
- FILL drives mem.valid=1, mem.write=0, mem.addr = {cpu.addr[ADDR_SIZE-1:2], 2'b00}.
- On mem.ready: write data, tag and valid bit; capture the word; go to RESP.
REQ-010 Write in IDLE (cpu.valid, cpu.write): go to WRITE_THRU.
- WRITE_THRU drives mem.valid=1, mem.write=1, mem.addr=cpu.addr, mem.wr_data=cpu.wr_data, mem.wr_size=cpu.wr_size.
- On mem.ready: if the access hit, byte-merge into the line; go to RESP.
REQ-011 Byte merge:
- byte: wr_data[7:0] into lane addr[1:0].
- half: wr_data[15:0] into lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
- word: full word; addr[1:0] is ignored.
REQ-012 RESP SHALL assert cpu.ready=1 for exactly one cycle, then return to IDLE.
- cpu.miss = 1 if the original lookup missed, else 0.
- cpu.rd_data = captured word on reads, don't-care on writes.
REQ-013 The hit/miss decision for a write SHALL be taken in IDLE and registered; a write miss leaves the array unchanged.
REQ-014 cpu.ready SHALL be 0 in FILL and WRITE_THRU, and in IDLE whenever the request misses or is a write.
REQ-015 mem.valid SHALL be 0 in IDLE and RESP; mem.rd_data is sampled only in FILL with mem.ready; mem.miss is ignored.
REQ-016 A new cpu request presented in the cycle after RESP SHALL be looked up normally, including a hit on the line just filled.
REQ-017 A read hit to an index whose write is in WRITE_THRU cannot occur; the core is blocked by REQ-014.

Reset
REQ-018 While reset_ni=0:
- state = IDLE.
- all valid bits = 0; tags and data are not reset.
- cpu.ready=0, cpu.miss=0, mem.valid=0, mem.write=0.
REQ-019 Reset asserted in FILL or WRITE_THRU SHALL abandon the transaction immediately (mem.valid low asynchronously); no array update occurs.

Structure
REQ-020 cache_access_size_t SHALL remain in package cache_interface_types.
REQ-021 The FSM state enum and derived INDEX_BITS/TAG_BITS helpers SHALL live in a new package dcache_types.
REQ-022 Tag/data/valid storage with combinational read and synchronous write SHALL be one sub-module, dcache_array.

Verification
REQ-023 After reset, read 0x0000_0100 (mem returns 0xDEAD_BEEF after 3 cycles) -> FILL for 3 cycles; RESP with rd_data=0xDEAD_BEEF, miss=1; an immediate re-read -> ready same cycle, miss=0, 0xDEAD_BEEF.
REQ-024 Line at 0x100 = 0xDEAD_BEEF; byte write 0x55 to 0x102 -> mem sees write addr 0x102, size byte; a later read hit returns 0xDE55_BEEF.
REQ-025 Write half 0x1234 to uncached 0x200 -> mem write issued, RESP miss=1; next read of 0x200 misses (no allocate).
REQ-026 Conflict: fill 0x100, then read 0x100 + NUM_LINES*4 -> miss, refill evicts; read 0x100 -> miss again.
REQ-027 Assert reset_ni low in mid-FILL -> mem.valid drops the same cycle; after release, read 0x100 -> miss=1.
REQ-028 mem.ready held low for 20 cycles during WRITE_THRU -> cpu.ready stays 0 throughout; exactly one RESP pulse after mem.ready.

Source files
------------

// File: rtl/cache_interface_types.sv
// Types shared by every user of cache_interface: the access size of a store.
package cache_interface_types;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } cache_access_size_t;

endpackage

// File: rtl/dcache_types.sv
// Data-cache FSM states and the address-split helpers derived from the geometry.
package dcache_types;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FILL       = 2'd1,
      WRITE_THRU = 2'd2,
      RESP       = 2'd3
   } dcache_state_t;

   function automatic int index_bits(input int num_lines);
      return $clog2(num_lines);
   endfunction

   // Two bits of byte offset sit below the index.
   function automatic int tag_bits(input int addr_size, input int num_lines);
      return addr_size - 2 - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/cache_interface.sv
// Request/response channel used both core-to-cache and cache-to-memory.
// Handshake: a transfer happens only in a cycle with valid && ready; the master
// holds addr, wr_data, wr_size and write stable from valid until that cycle.
interface cache_interface
   import cache_interface_types::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
);
   logic                 valid;
   logic                 ready;
   logic                 write;
   logic                 miss;
   logic [ADDR_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] wr_data;
   logic [WORD_SIZE-1:0] rd_data;
   cache_access_size_t   wr_size;

   modport master (output valid, addr, wr_data, wr_size, write,
                   input  ready, rd_data, miss);
   modport slave  (input  valid, addr, wr_data, wr_size, write,
                   output ready, rd_data, miss);
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, synchronous write.
// Only the valid bits are reset; tag and data contents are meaningless until filled.
module dcache_array #(
   parameter int NUM_LINES  = 64,
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 24,
   parameter int WORD_SIZE  = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [INDEX_BITS-1:0] index,
   input  logic                  wr_en,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [WORD_SIZE-1:0]  wr_data,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [WORD_SIZE-1:0]  rd_data
);
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
   logic [WORD_SIZE-1:0] data_mem [NUM_LINES];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[index] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_mem[index]  <= wr_tag;
         data_mem[index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[index];
   assign rd_tag   = tag_mem[index];
   assign rd_data  = data_mem[index];
endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache.
// Read hits complete in IDLE; misses and all writes go through memory, then RESP.
module dcache
   import cache_interface_types::*;
   import dcache_types::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32,
   parameter int NUM_LINES = 64
) (
   input logic            clk_i,
   input logic            reset_ni,
   cache_interface.slave  cpu,
   cache_interface.master mem
);
   localparam int INDEX_BITS = index_bits(NUM_LINES);
   localparam int TAG_BITS   = tag_bits(ADDR_SIZE, NUM_LINES);

   dcache_state_t         state_q, state_d;
   logic                  hit_q;
   logic [WORD_SIZE-1:0]  rd_q;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic                  arr_valid, arr_we, lookup_hit;
   logic [TAG_BITS-1:0]   arr_tag;
   logic [WORD_SIZE-1:0]  arr_data, arr_wdata, merged;
   logic                  unused_mem_miss;

   assign index           = cpu.addr[2 +: INDEX_BITS];
   assign tag             = cpu.addr[ADDR_SIZE-1 -: TAG_BITS];
   assign lookup_hit      = arr_valid && (arr_tag == tag);
   assign unused_mem_miss = mem.miss;

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS),
      .WORD_SIZE (WORD_SIZE)
   ) u_array (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .index   (index),
      .wr_en   (arr_we),
      .wr_tag  (tag),
      .wr_data (arr_wdata),
      .rd_valid(arr_valid),
      .rd_tag  (arr_tag),
      .rd_data (arr_data)
   );

   // Store data merged into the resident word; only written back on a write hit.
   always_comb begin
      merged = arr_data;
      case (cpu.wr_size)
         SIZE_BYTE: merged[{cpu.addr[1:0], 3'b000} +: 8]  = cpu.wr_data[7:0];
         SIZE_HALF: merged[{cpu.addr[1], 4'b0000} +: 16]  = cpu.wr_data[15:0];
         default:   merged = cpu.wr_data;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         hit_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cpu.valid && !cpu.ready) begin
            hit_q <= lookup_hit;
         end
         if (state_q == FILL && mem.ready) begin
            rd_q <= mem.rd_data;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      arr_we      = 1'b0;
      arr_wdata   = mem.rd_data;
      cpu.ready   = 1'b0;
      cpu.miss    = 1'b0;
      cpu.rd_data = (state_q == RESP) ? rd_q : arr_data;
      mem.valid   = 1'b0;
      mem.write   = 1'b0;
      mem.addr    = cpu.addr;
      mem.wr_data = cpu.wr_data;
      mem.wr_size = cpu.wr_size;
      case (state_q)
         IDLE: begin
            if (cpu.valid) begin
               if (cpu.write) begin
                  state_d = WRITE_THRU;
               end else if (lookup_hit) begin
                  cpu.ready = 1'b1;
               end else begin
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            mem.valid = 1'b1;
            mem.addr  = {cpu.addr[ADDR_SIZE-1:2], 2'b00};
            if (mem.ready) begin
               arr_we  = 1'b1;
               state_d = RESP;
            end
         end
         WRITE_THRU: begin
            mem.valid = 1'b1;
            mem.write = 1'b1;
            arr_wdata = merged;
            if (mem.ready) begin
               arr_we  = hit_q;
               state_d = RESP;
            end
         end
         RESP: begin
            cpu.ready = 1'b1;
            cpu.miss  = ~hit_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
